// File: rtl/fp_to_linear.sv
// Sequential decoder from the 8-bit float format (S, E, F) to a D_W-bit two's-complement value.
// Define FPDEC_BARREL_EN to replace the one-bit-per-cycle shifter with a single barrel shift.
module fp_to_linear #(
    parameter int E_W = 3,
    parameter int F_W = 4,
    parameter int D_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           s,
    input  logic [E_W-1:0] e,
    input  logic [F_W-1:0] f,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [D_W-1:0] acc_q, acc_d;
    logic [D_W-1:0] d_q, d_d;
    logic           sign_q, sign_d;

`ifdef FPDEC_BARREL_EN
    // Barrel build: e is kept for the one-shot shift, and a phase bit adds one
    // settle cycle so latency is a constant 3 cycles for every exponent.
    logic [E_W-1:0] e_q, e_d;
    logic           phase_q, phase_d;
`else
    logic [E_W-1:0] cnt_q, cnt_d;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        d_d     = d_q;
        sign_d  = sign_q;
`ifdef FPDEC_BARREL_EN
        e_d     = e_q;
        phase_d = phase_q;
`else
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = D_W'(f);
                    sign_d  = s;
`ifdef FPDEC_BARREL_EN
                    e_d     = e;
                    phase_d = 1'b0;
`else
                    cnt_d   = e;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef FPDEC_BARREL_EN
                if (!phase_q) begin
                    acc_d   = acc_q << e_q;
                    phase_d = 1'b1;
                end else begin
                    state_d = SIGN;
                end
`else
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end else begin
                    acc_d = acc_q << 1;
                    cnt_d = cnt_q - E_W'(1);
                end
`endif
            end
            SIGN: begin
                // Negating zero gives zero, so a negative-zero input decodes to 0.
                d_d     = sign_q ? -acc_q : acc_q;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop here is a
    // plain register (no memory array), so all of them are cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            d_q     <= '0;
            sign_q  <= 1'b0;
`ifdef FPDEC_BARREL_EN
            e_q     <= '0;
            phase_q <= 1'b0;
`else
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            sign_q  <= sign_d;
`ifdef FPDEC_BARREL_EN
            e_q     <= e_d;
            phase_q <= phase_d;
`else
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Handshake flags decode straight from state, so reset clears them without a clock edge.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign d         = d_q;

endmodule
